// File: rtl/load_store_unit.sv
// Load/store unit: data-memory access stage of the multicycle core.
// Accepts one access from the core over a valid/ready handshake. Misaligned or
// illegal-funct3 requests are answered without touching memory. Legal requests
// run a req/ack handshake toward the data memory, with a cycle limit that aborts
// the access with a timeout error. Handles store lane steering, byte enables,
// and load lane extraction with sign/zero extension.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  // core side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  // memory side
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // Counter is wide enough to hold TIMEOUT_CYCLES itself.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_MISALIGN  = 2'b01;
  localparam logic [1:0] ERR_FUNCT3    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_t;

  state_t state_reg, state_next;

  // latched request fields needed after the accept cycle
  logic             write_reg;
  logic [2:0]       funct3_reg;
  logic [1:0]       addr_lo_reg;
  logic [CNT_W-1:0] cnt_reg;

  // registered memory-side outputs
  logic        mem_we_reg;
  logic [3:0]  mem_be_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;

  // registered response
  logic [31:0] resp_rdata_reg;
  logic [1:0]  resp_err_reg;

  // combinational helpers
  logic        req_accept;
  logic        funct3_legal;
  logic        misaligned;
  logic [1:0]  accept_err;
  logic        timeout_hit;
  logic        access_done;
  logic [3:0]  steer_be;
  logic [31:0] steer_wdata;
  logic [7:0]  rdata_lane [4];
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  wire is_byte = (req_funct3[1:0] == 2'b00);
  wire is_half = (req_funct3[1:0] == 2'b01);

  assign req_accept  = req_valid && (state_reg == S_IDLE);
  assign timeout_hit = (state_reg == S_ACCESS) && !mem_ack && (cnt_reg == CNT_LAST);
  assign access_done = (state_reg == S_ACCESS) && (mem_ack || timeout_hit);

  // Classify the incoming request; illegal funct3 outranks misalignment.
  always_comb begin
    funct3_legal = 1'b0;
    misaligned   = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
      3'b100, 3'b101:         funct3_legal = !req_write;
      default:                funct3_legal = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    if (!funct3_legal)
      accept_err = ERR_FUNCT3;
    else if (misaligned)
      accept_err = ERR_MISALIGN;
    else
      accept_err = ERR_OK;
  end

  // Store steering per byte lane: bytes replicate to all lanes, halves to both
  // halves; loads read the full word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
      assign steer_be[gi] = !req_write ? 1'b1 :
                            is_byte    ? (req_addr[1:0] == 2'(gi)) :
                            is_half    ? (req_addr[1] == ((gi / 2) != 0)) :
                                         1'b1;
      assign steer_wdata[8*gi +: 8] = !req_write ? 8'h00 :
                                      is_byte    ? req_wdata[7:0] :
                                      is_half    ? req_wdata[8*(gi % 2) +: 8] :
                                                   req_wdata[8*gi +: 8];
      assign rdata_lane[gi] = mem_rdata[8*gi +: 8];
    end
  endgenerate

  // Extract and extend the addressed lane of the returned word.
  always_comb begin
    lane_byte = rdata_lane[addr_lo_reg];
    lane_half = addr_lo_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_reg)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_data = {24'h000000, lane_byte};
      3'b101:  load_data = {16'h0000, lane_half};
      default: load_data = mem_rdata;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    resp_valid = 1'b0;
    case (state_reg)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_next = (accept_err != ERR_OK) ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        mem_req = 1'b1;
        if (mem_ack || timeout_hit)
          state_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Latch the request fields that the load extraction needs later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_reg   <= 1'b0;
      funct3_reg  <= 3'b000;
      addr_lo_reg <= 2'b00;
    end else if (req_accept) begin
      write_reg   <= req_write;
      funct3_reg  <= req_funct3;
      addr_lo_reg <= req_addr[1:0];
    end
  end

  // Count ACCESS cycles without ack; cleared everywhere else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_reg <= '0;
    else if (state_reg != S_ACCESS)
      cnt_reg <= '0;
    else if (!mem_ack)
      cnt_reg <= cnt_reg + CNT_W'(1);
  end

  // Memory-side command registers: loaded on a clean accept, cleared when the
  // access ends so they read zero outside ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we_reg    <= 1'b0;
      mem_be_reg    <= 4'b0000;
      mem_addr_reg  <= 32'h0;
      mem_wdata_reg <= 32'h0;
    end else if (req_accept && (accept_err == ERR_OK)) begin
      mem_we_reg    <= req_write;
      mem_be_reg    <= steer_be;
      mem_addr_reg  <= {req_addr[31:2], 2'b00};
      mem_wdata_reg <= steer_wdata;
    end else if (access_done) begin
      mem_we_reg    <= 1'b0;
      mem_be_reg    <= 4'b0000;
      mem_addr_reg  <= 32'h0;
      mem_wdata_reg <= 32'h0;
    end
  end

  // Response registers update only when a new response is produced; an ack
  // that coincides with the last counted cycle completes normally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_rdata_reg <= 32'h0;
      resp_err_reg   <= ERR_OK;
    end else if (req_accept && (accept_err != ERR_OK)) begin
      resp_rdata_reg <= 32'h0;
      resp_err_reg   <= accept_err;
    end else if ((state_reg == S_ACCESS) && mem_ack) begin
      resp_rdata_reg <= write_reg ? 32'h0 : load_data;
      resp_err_reg   <= ERR_OK;
    end else if (timeout_hit) begin
      resp_rdata_reg <= 32'h0;
      resp_err_reg   <= ERR_TIMEOUT;
    end
  end

  assign mem_we     = mem_we_reg;
  assign mem_be     = mem_be_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

endmodule
